// File: rtl/rgb_sram_writer_if.sv
// Pixel-stream and SRAM-write bundle for the RGB packer.
// Carries no state of its own, so it adds no latency.
// pixel_valid/pixel_ready carry the handshake. The SRAM side is write-only and has no stall.
interface rgb_sram_writer_if;
  logic        start;
  logic [17:0] SRAM_base_address;
  logic        pixel_valid;
  logic [7:0]  pixel_R;
  logic [7:0]  pixel_G;
  logic [7:0]  pixel_B;
  logic        pixel_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        busy;
  logic        done;

  // Upstream producer / frame controller side
  modport master (
    output start, SRAM_base_address, pixel_valid, pixel_R, pixel_G, pixel_B,
    input  pixel_ready, SRAM_address, SRAM_write_data, SRAM_we_n, busy, done
  );

  // Packer side
  modport slave (
    input  start, SRAM_base_address, pixel_valid, pixel_R, pixel_G, pixel_B,
    output pixel_ready, SRAM_address, SRAM_write_data, SRAM_we_n, busy, done
  );
endinterface

// File: rtl/rgb_sram_writer.sv
// Packs raster RGB pixel pairs into three 16-bit SRAM words at consecutive addresses.
// The first write strobe appears one cycle after the odd pixel is accepted. Three writes follow on back-to-back cycles.
// pixel_ready stays low for 3 cycles after each odd pixel, so peak throughput is 2 pixels per 5 cycles.
module rgb_sram_writer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic             Clock,
  input  logic             Reset,
  rgb_sram_writer_if.slave bus
);

  localparam int          PAIRS     = IMG_WIDTH * IMG_HEIGHT / 2;
  localparam logic [16:0] LAST_PAIR = 17'(PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_EVEN, S_WAIT_ODD, S_WRITE_1, S_WRITE_2, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [17:0] word_ptr, word_ptr_nxt;
  logic [16:0] pair_cnt, pair_cnt_nxt;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        lat_even, lat_odd;

  logic        ready_q, ready_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;
  logic        we_n_q, we_n_nxt;
  logic [17:0] addr_q, addr_nxt;
  logic [15:0] data_q, data_nxt;

  logic        accept;

  assign accept = bus.pixel_valid & ready_q;

  assign bus.pixel_ready     = ready_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.SRAM_we_n       = we_n_q;
  assign bus.SRAM_address    = addr_q;
  assign bus.SRAM_write_data = data_q;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and next registered outputs. The write outputs hold their values unless a write is issued.
  always_comb begin
    state_nxt    = state;
    ready_nxt    = ready_q;
    busy_nxt     = busy_q;
    done_nxt     = 1'b0;
    we_n_nxt     = 1'b1;
    addr_nxt     = addr_q;
    data_nxt     = data_q;
    word_ptr_nxt = word_ptr;
    pair_cnt_nxt = pair_cnt;
    lat_even     = 1'b0;
    lat_odd      = 1'b0;
    case (state)
      S_IDLE: begin
        ready_nxt = 1'b0;
        busy_nxt  = 1'b0;
        if (bus.start) begin
          word_ptr_nxt = bus.SRAM_base_address;
          pair_cnt_nxt = '0;
          busy_nxt     = 1'b1;
          ready_nxt    = 1'b1;
          state_nxt    = S_WAIT_EVEN;
        end
      end
      S_WAIT_EVEN: begin
        // pixel_ready rises on the first cycle here after a pair's writes. That cycle is the third low cycle of the pair.
        ready_nxt = 1'b1;
        if (accept) begin
          lat_even  = 1'b1;
          state_nxt = S_WAIT_ODD;
        end
      end
      S_WAIT_ODD: begin
        ready_nxt = 1'b1;
        if (accept) begin
          lat_odd   = 1'b1;
          ready_nxt = 1'b0;
          addr_nxt  = word_ptr;
          data_nxt  = {r0, g0};
          we_n_nxt  = 1'b0;
          state_nxt = S_WRITE_1;
        end
      end
      S_WRITE_1: begin
        ready_nxt = 1'b0;
        addr_nxt  = word_ptr + 18'd1;
        data_nxt  = {b0, r1};
        we_n_nxt  = 1'b0;
        state_nxt = S_WRITE_2;
      end
      S_WRITE_2: begin
        ready_nxt    = 1'b0;
        addr_nxt     = word_ptr + 18'd2;
        data_nxt     = {g1, b1};
        we_n_nxt     = 1'b0;
        word_ptr_nxt = word_ptr + 18'd3;
        pair_cnt_nxt = pair_cnt + 17'd1;
        state_nxt    = (pair_cnt == LAST_PAIR) ? S_DONE : S_WAIT_EVEN;
      end
      S_DONE: begin
        ready_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs, frame counters and the pixel-pair latches
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_n_q   <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      word_ptr <= '0;
      pair_cnt <= '0;
      r0 <= '0; g0 <= '0; b0 <= '0;
      r1 <= '0; g1 <= '0; b1 <= '0;
    end else begin
      ready_q  <= ready_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      we_n_q   <= we_n_nxt;
      addr_q   <= addr_nxt;
      data_q   <= data_nxt;
      word_ptr <= word_ptr_nxt;
      pair_cnt <= pair_cnt_nxt;
      if (lat_even) begin
        r0 <= bus.pixel_R; g0 <= bus.pixel_G; b0 <= bus.pixel_B;
      end
      if (lat_odd) begin
        r1 <= bus.pixel_R; g1 <= bus.pixel_G; b1 <= bus.pixel_B;
      end
    end
  end

endmodule
